// File: rtl/tick_gen_pkg.sv
// Shared types for the programmable tick generator: channel modes, channel states
// and the config-write validity check.
package tick_gen_pkg;

  localparam int MAX_CH = 16;
  localparam int CHAN_W = $clog2(MAX_CH);

  typedef enum logic [1:0] {
    MODE_PERIODIC = 2'd0,
    MODE_ONESHOT  = 2'd1,
    MODE_TOGGLE   = 2'd2,
    MODE_RSVD     = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // A write is rejected when it targets a missing channel or uses the reserved mode.
  function automatic logic cfg_is_bad(input logic [CHAN_W-1:0] chan,
                                      input logic [1:0]        mode,
                                      input int                n_ch);
    return (int'(chan) >= n_ch) || (mode == MODE_RSVD);
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One tick/level channel: counter 0..div, run/idle state, live and shadow
// divide/mode settings, registered tick strobe and square-wave level.
module tick_channel
  import tick_gen_pkg::*;
#(
  parameter int               CNT_W       = 32,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [CNT_W-1:0] wr_div_i,
  input  mode_e            wr_mode_i,
  input  logic             start_i,
  input  logic             stop_i,
  output logic             tick_o,
  output logic             level_o,
  output logic             busy_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] shadow_div_q, shadow_div_d;
  mode_e            shadow_mode_q, shadow_mode_d;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             level_q, level_d;

  logic             tc;
  logic [CNT_W-1:0] settle_div;
  mode_e            settle_mode;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      div_q         <= DEFAULT_DIV;
      mode_q        <= MODE_PERIODIC;
      shadow_div_q  <= '0;
      shadow_mode_q <= MODE_PERIODIC;
      pend_q        <= 1'b0;
      tick_q        <= 1'b0;
      level_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      div_q         <= div_d;
      mode_q        <= mode_d;
      shadow_div_q  <= shadow_div_d;
      shadow_mode_q <= shadow_mode_d;
      pend_q        <= pend_d;
      tick_q        <= tick_d;
      level_q       <= level_d;
    end
  end

  assign tc = (cnt_q == div_q);

  // Settings adopted when a period is abandoned or the channel comes to rest:
  // a same-cycle write beats a pending shadow, which beats the live value.
  assign settle_div  = wr_en_i ? wr_div_i  : (pend_q ? shadow_div_q  : div_q);
  assign settle_mode = wr_en_i ? wr_mode_i : (pend_q ? shadow_mode_q : mode_q);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    div_d         = div_q;
    mode_d        = mode_q;
    shadow_div_d  = shadow_div_q;
    shadow_mode_d = shadow_mode_q;
    pend_d        = pend_q;
    tick_d        = 1'b0;
    level_d       = level_q;

    case (state_q)
      ST_IDLE: begin
        if (wr_en_i) begin
          div_d  = wr_div_i;
          mode_d = wr_mode_i;
        end
        if (start_i && !stop_i) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end

      ST_RUN: begin
        if (stop_i || start_i) begin
          cnt_d  = '0;
          div_d  = settle_div;
          mode_d = settle_mode;
          pend_d = 1'b0;
          if (stop_i) begin
            state_d = ST_IDLE;
          end
        end else if (tc) begin
          cnt_d   = '0;
          level_d = ~level_q;
          tick_d  = (mode_q != MODE_TOGGLE);
          if (mode_q == MODE_ONESHOT) begin
            state_d = ST_IDLE;
            div_d   = settle_div;
            mode_d  = settle_mode;
            pend_d  = 1'b0;
          end else begin
            // A write landing on the TC itself waits for the following TC.
            if (pend_q) begin
              div_d  = shadow_div_q;
              mode_d = shadow_mode_q;
            end
            pend_d = wr_en_i;
            if (wr_en_i) begin
              shadow_div_d  = wr_div_i;
              shadow_mode_d = wr_mode_i;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (wr_en_i) begin
            shadow_div_d  = wr_div_i;
            shadow_mode_d = wr_mode_i;
            pend_d        = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign tick_o  = tick_q;
  assign level_o = level_q;
  assign busy_o  = (state_q == ST_RUN);

endmodule

// File: rtl/multi_tick_gen.sv
// N-channel programmable clock-enable generator: config decode, error pulse and
// per-channel write-enable fan-out around an array of tick_channel instances.
module multi_tick_gen
  import tick_gen_pkg::*;
#(
  parameter int               N_CH        = 4,
  parameter int               CNT_W       = 32,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(37499999)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CHAN_W-1:0] cfg_chan,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [1:0]        cfg_mode,
  output logic              cfg_err,
  input  logic [N_CH-1:0]   start,
  input  logic [N_CH-1:0]   stop,
  output logic [N_CH-1:0]   busy,
  output logic [N_CH-1:0]   tick,
  output logic [N_CH-1:0]   level
);

  logic            ready_q;
  logic            err_q, err_d;
  logic            cfg_accept;
  logic            cfg_bad;
  logic            cfg_write;
  logic [N_CH-1:0] wr_en;
  mode_e           wr_mode;

  // Ready rises on the first edge after reset release, never during reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      err_q   <= err_d;
    end
  end

  assign cfg_ready  = ready_q;
  assign cfg_accept = cfg_valid & ready_q;
  assign cfg_bad    = cfg_is_bad(cfg_chan, cfg_mode, N_CH);
  assign cfg_write  = cfg_accept & ~cfg_bad;
  assign err_d      = cfg_accept & cfg_bad;
  assign cfg_err    = err_q;
  assign wr_mode    = mode_e'(cfg_mode);

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    assign wr_en[gi] = cfg_write & (cfg_chan == CHAN_W'(gi));

    tick_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .wr_en_i   (wr_en[gi]),
      .wr_div_i  (cfg_div),
      .wr_mode_i (wr_mode),
      .start_i   (start[gi]),
      .stop_i    (stop[gi]),
      .tick_o    (tick[gi]),
      .level_o   (level[gi]),
      .busy_o    (busy[gi])
    );
  end

endmodule

// File: tb/tb_multi_tick_gen.sv
// Directed bench for multi_tick_gen: a cycle-count based model checked every
// cycle, plus hand-computed tick spacings and handshake expectations.
module tb_multi_tick_gen;

  localparam int N_CH    = 4;
  localparam int CNT_W   = 32;
  localparam int DEF_DIV = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [3:0]       cfg_chan = '0;
  logic [CNT_W-1:0] cfg_div = '0;
  logic [1:0]       cfg_mode = '0;
  logic             cfg_err;
  logic [N_CH-1:0]  start = '0;
  logic [N_CH-1:0]  stop = '0;
  logic [N_CH-1:0]  busy;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  level;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_tick_gen #(
    .N_CH        (N_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (32'd4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_div   (cfg_div),
    .cfg_mode  (cfg_mode),
    .cfg_err   (cfg_err),
    .start     (start),
    .stop      (stop),
    .busy      (busy),
    .tick      (tick),
    .level     (level)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a running channel's period began at edge m_pstart; its terminal
  // count is the edge where (edge - m_pstart) == div + 1.
  int unsigned     m_div     [N_CH];
  int unsigned     m_sh_div  [N_CH];
  int              m_mode    [N_CH];
  int              m_sh_mode [N_CH];
  bit              m_pend    [N_CH];
  longint          m_pstart  [N_CH];
  logic [N_CH-1:0] m_run, m_tick, m_level;
  logic            m_err, m_ready;
  longint          cyc;

  task automatic m_clear();
    for (int c = 0; c < N_CH; c++) begin
      m_div[c]     = DEF_DIV;
      m_mode[c]    = 0;
      m_sh_div[c]  = 0;
      m_sh_mode[c] = 0;
      m_pend[c]    = 1'b0;
      m_pstart[c]  = 0;
    end
    m_run   = '0;
    m_tick  = '0;
    m_level = '0;
    m_err   = 1'b0;
    m_ready = 1'b0;
    cyc     = 0;
  endtask

  task automatic m_step();
    bit acc, bad, wr, tc;
    int unsigned nd;
    int nm;
    acc   = cfg_valid && m_ready;
    bad   = (int'(cfg_chan) >= N_CH) || (cfg_mode == 2'd3);
    m_err = acc && bad;
    for (int c = 0; c < N_CH; c++) begin
      wr = acc && !bad && (int'(cfg_chan) == c);
      nd = wr ? cfg_div : (m_pend[c] ? m_sh_div[c] : m_div[c]);
      nm = wr ? int'(cfg_mode) : (m_pend[c] ? m_sh_mode[c] : m_mode[c]);
      m_tick[c] = 1'b0;
      if (!m_run[c]) begin
        if (wr) begin
          m_div[c]  = cfg_div;
          m_mode[c] = int'(cfg_mode);
        end
        if (start[c] && !stop[c]) begin
          m_run[c]    = 1'b1;
          m_pstart[c] = cyc;
        end
      end else begin
        tc = (cyc - m_pstart[c]) == (longint'(m_div[c]) + 1);
        if (stop[c] || start[c]) begin
          m_div[c]  = nd;
          m_mode[c] = nm;
          m_pend[c] = 1'b0;
          if (stop[c]) m_run[c] = 1'b0;
          else m_pstart[c] = cyc;
        end else if (tc) begin
          m_tick[c]  = (m_mode[c] != 2);
          m_level[c] = !m_level[c];
          if (m_mode[c] == 1) begin
            m_run[c]  = 1'b0;
            m_div[c]  = nd;
            m_mode[c] = nm;
            m_pend[c] = 1'b0;
          end else begin
            m_pstart[c] = cyc;
            if (m_pend[c]) begin
              m_div[c]  = m_sh_div[c];
              m_mode[c] = m_sh_mode[c];
            end
            m_pend[c] = wr;
            if (wr) begin
              m_sh_div[c]  = cfg_div;
              m_sh_mode[c] = int'(cfg_mode);
            end
          end
        end else if (wr) begin
          m_sh_div[c]  = cfg_div;
          m_sh_mode[c] = int'(cfg_mode);
          m_pend[c]    = 1'b1;
        end
      end
    end
    m_ready = 1'b1;
    cyc++;
  endtask

  initial begin
    m_clear();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) m_clear();
      else m_step();
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("cyc_busy", 32'(busy), 32'(m_run));
      chk("cyc_tick", 32'(tick), 32'(m_tick));
      chk("cyc_level", 32'(level), 32'(m_level));
      chk("cyc_cfg_err", 32'(cfg_err), 32'(m_err));
      chk("cyc_cfg_ready", 32'(cfg_ready), 32'(m_ready));
    end
  end

  task automatic wait_tick(input int ch, output int n);
    n = -1;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (tick[ch]) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic drive_cfg(input int ch, input int unsigned dv, input int md);
    cfg_valid = 1'b1;
    cfg_chan  = 4'(ch);
    cfg_div   = CNT_W'(dv);
    cfg_mode  = 2'(md);
    $display("cfg write: ch=%0d div=%0d mode=%0d at %0t", ch, dv, md, $time);
  endtask

  initial begin
    int n;
    int cnt;
    logic lv;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(cfg_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tick", 32'(tick), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(cfg_ready), 1);

    // ch0 default div=4: tick every 5 cycles
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    $display("start ch0 at %0t", $time);
    chk("ch0_busy", 32'(busy[0]), 1);
    wait_tick(0, n);
    chk("ch0_first_tick", n, 5);
    chk("ch0_level1", 32'(level[0]), 1);
    wait_tick(0, n);
    chk("ch0_period", n, 5);
    chk("ch0_level2", 32'(level[0]), 0);

    // ch1 div=0 written together with start
    drive_cfg(1, 0, 0);
    start[1] = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    start[1]  = 1'b0;
    @(negedge clk);
    chk("ch1_tick_first", 32'(tick[1]), 1);
    lv = level[1];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ch1_tick_hold", 32'(tick[1]), 1);
      chk("ch1_level_alt", 32'(level[1]), 32'(!lv));
      lv = level[1];
    end
    stop[1] = 1'b1;
    @(negedge clk);
    stop[1] = 1'b0;
    $display("stop ch1 at %0t", $time);
    chk("ch1_stop_busy", 32'(busy[1]), 0);
    chk("ch1_stop_tick", 32'(tick[1]), 0);

    // ch2 ONESHOT div=3
    drive_cfg(2, 3, 1);
    start[2] = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    start[2]  = 1'b0;
    wait_tick(2, n);
    chk("ch2_oneshot_delay", n, 4);
    chk("ch2_busy_fall", 32'(busy[2]), 0);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (tick[2]) cnt++;
    end
    chk("ch2_no_more_ticks", cnt, 0);

    // ch0 div=9, rewritten to 2 mid-period at cnt=5
    stop[0] = 1'b1;
    @(negedge clk);
    stop[0] = 1'b0;
    chk("ch0_stopped", 32'(busy[0]), 0);
    drive_cfg(0, 9, 0);
    @(negedge clk);
    cfg_valid = 1'b0;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (5) @(negedge clk);
    drive_cfg(0, 2, 0);
    @(negedge clk);
    cfg_valid = 1'b0;
    wait_tick(0, n);
    chk("ch0_old_div_done", n, 4);
    wait_tick(0, n);
    chk("ch0_new_period_a", n, 3);
    wait_tick(0, n);
    chk("ch0_new_period_b", n, 3);

    // Restart exactly at terminal count suppresses the tick
    repeat (2) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    $display("restart ch0 at %0t", $time);
    chk("ch0_restart_no_tick", 32'(tick[0]), 0);
    wait_tick(0, n);
    chk("ch0_after_restart", n, 3);

    // start+stop together on running ch3
    start[3] = 1'b1;
    @(negedge clk);
    start[3] = 1'b0;
    repeat (2) @(negedge clk);
    start[3] = 1'b1;
    stop[3]  = 1'b1;
    @(negedge clk);
    start[3] = 1'b0;
    stop[3]  = 1'b0;
    chk("ch3_stop_wins", 32'(busy[3]), 0);

    // Bad channel and reserved mode writes
    drive_cfg(7, 1, 0);
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("err_bad_chan", 32'(cfg_err), 1);
    @(negedge clk);
    chk("err_pulse_end", 32'(cfg_err), 0);
    drive_cfg(1, 7, 3);
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("err_rsvd_mode", 32'(cfg_err), 1);

    // Dropped writes must leave ch1 (div=0) and ch3 (div=4) untouched
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    wait_tick(1, n);
    chk("ch1_div_kept", n, 1);
    stop[1] = 1'b1;
    @(negedge clk);
    stop[1] = 1'b0;
    start[3] = 1'b1;
    @(negedge clk);
    start[3] = 1'b0;
    wait_tick(3, n);
    chk("ch3_div_kept", n, 5);

    // Reset at cnt=div-1 on ch3
    repeat (3) @(negedge clk);
    reset = 1'b1;
    $display("reset asserted at %0t", $time);
    #1;
    chk("midrst_tick", 32'(tick), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_level", 32'(level), 0);
    chk("midrst_ready", 32'(cfg_ready), 0);
    repeat (3) @(negedge clk);
    chk("midrst_no_tick", 32'(tick), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(cfg_ready), 1);
    chk("post_rst_idle", 32'(busy), 0);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
